// File: rtl/param_reg_file.sv
// Parametrised register file: DATA_W x 2**ADDR_W entries, one write port, NUM_RD
// combinational read ports, per-entry busy scoreboard and live busy count.
// Optional feature macro: PRF_BYPASS_EN (write-to-read forwarding in the same cycle).
module param_reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              set_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  // Entry 0 is hardwired to zero when ZERO_REG is set: writes and busy marks are dropped.
  assign wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
  assign set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

  // A busy mark on the same edge as the retiring write wins: the new load is still pending.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[waddr]     = 1'b0;
    if (set_ok) busy_nxt[busy_addr] = 1'b1;
  end

  assign cnt_inc = set_ok && !busy[busy_addr];
  assign cnt_dec = wr_ok && busy[waddr] && !(set_ok && (busy_addr == waddr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              fwd;

    assign ra      = raddr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
`ifdef PRF_BYPASS_EN
    assign fwd     = wr_ok && (waddr == ra);
`else
    assign fwd     = 1'b0;
`endif

    assign rdata[k*DATA_W +: DATA_W] = is_zero ? '0 : (fwd ? wdata : mem[ra]);
    assign rbusy[k] = is_zero ? 1'b0 : (fwd ? (set_ok && (busy_addr == ra)) : busy[ra]);
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Randomised bench for param_reg_file: two instances (ZERO_REG=1 and ZERO_REG=0)
// compared against an array-based reference model of the register file.
module tb_param_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NREG = 2 ** AW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;
  logic              busy_set;
  logic [AW-1:0]     busy_addr;
  logic [NR*DW-1:0]  rdata_z, rdata_n;
  logic [NR-1:0]     rbusy_z, rbusy_n;
  logic [AW:0]       cnt_z, cnt_n;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
  logic [DW-1:0] m_mem  [2][NREG];
  bit            m_busy [2][NREG];

  param_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_z), .rbusy(rbusy_z),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_cnt(cnt_z));

  param_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_cnt(cnt_n));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_zr(int d, int a);
    return (d == 0) && (a == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int d, int a);
    if (is_zr(d, a)) return '0;
`ifdef PRF_BYPASS_EN
    if (we && (int'(waddr) == a)) return wdata;
`endif
    return m_mem[d][a];
  endfunction

  function automatic bit exp_rb(int d, int a);
    if (is_zr(d, a)) return 1'b0;
`ifdef PRF_BYPASS_EN
    if (we && (int'(waddr) == a)) return busy_set && (int'(busy_addr) == a);
`endif
    return m_busy[d][a];
  endfunction

  function automatic int exp_cnt(int d);
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[d][i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NREG; i++) begin
        m_mem[d][i]  = '0;
        m_busy[d][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (we && !is_zr(d, int'(waddr))) begin
        m_mem[d][waddr]  = wdata;
        m_busy[d][waddr] = 1'b0;
      end
      if (busy_set && !is_zr(d, int'(busy_addr))) m_busy[d][busy_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NR; k++) begin
        int a;
        logic [DW-1:0] rd;
        logic          rb;
        a  = int'(raddr[k*AW +: AW]);
        rd = (d == 0) ? rdata_z[k*DW +: DW] : rdata_n[k*DW +: DW];
        rb = (d == 0) ? rbusy_z[k] : rbusy_n[k];
        check($sformatf("%s_d%0d_rdata%0d", tag, d, k), 64'(rd), 64'(exp_rd(d, a)));
        check($sformatf("%s_d%0d_rbusy%0d", tag, d, k), 64'(rb), 64'(exp_rb(d, a)));
      end
      check($sformatf("%s_d%0d_cnt", tag, d), 64'((d == 0) ? cnt_z : cnt_n), 64'(exp_cnt(d)));
    end
  endtask

  task automatic drive(input logic w, input int wa, input logic [DW-1:0] wd,
                       input logic bs, input int ba, input int ra0, input int ra1);
    we        = w;
    waddr     = AW'(wa);
    wdata     = wd;
    busy_set  = bs;
    busy_addr = AW'(ba);
    raddr     = {AW'(ra1), AW'(ra0)};
  endtask

  // Called just after a negedge: check pre-edge, clock, update model, check post-edge.
  task automatic step(input string tag);
    #1 check_outputs({tag, "_pre"});
    @(posedge clk);
    model_edge();
    #1 check_outputs({tag, "_post"});
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; any write held across it is discarded.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    model_clear();
    #1 check_outputs({tag, "_async"});
    @(posedge clk);
    #1 check_outputs({tag, "_held"});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic int pick_addr();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    reset_n = 1'b0;
    model_clear();
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
    @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;

    // Reset discards stored data and an in-flight write.
    drive(1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 3, 3);
    step("t1_wr");
    check("t1_stored", 64'(rdata_z[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    drive(1'b1, 3, 32'h1234_5678, 1'b1, 6, 3, 6);
    do_reset("t1_rst");
    check("t1_rd_after_rst", 64'(rdata_z[DW-1:0]), 64'h0);
    drive(1'b0, 0, '0, 1'b0, 0, 3, 6);
    step("t1_idle");

    // Zero register: ignored on the ZERO_REG=1 instance, ordinary on the other.
    drive(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    step("t2_zero");
    check("t2_z_rdata", 64'(rdata_z[DW-1:0]), 64'h0);
    check("t2_z_rbusy", 64'(rbusy_z[0]), 64'h0);
    check("t2_z_cnt", 64'(cnt_z), 64'h0);
    check("t2_n_rdata", 64'(rdata_n[DW-1:0]), 64'hFFFF_FFFF);
    check("t2_n_cnt", 64'(cnt_n), 64'h1);

    // Scoreboard set and writeback clear.
    drive(1'b0, 0, '0, 1'b1, 5, 5, 7);
    step("t3_set5");
    check("t3_cnt1", 64'(cnt_z), 64'h1);
    drive(1'b0, 0, '0, 1'b1, 7, 5, 7);
    step("t3_set7");
    check("t3_cnt2", 64'(cnt_z), 64'h2);
    check("t3_rbusy5", 64'(rbusy_z[0]), 64'h1);
    drive(1'b1, 5, 32'h12, 1'b0, 0, 5, 7);
    step("t3_wb5");
    check("t3_cnt_wb", 64'(cnt_z), 64'h1);
    check("t3_rbusy5_clr", 64'(rbusy_z[0]), 64'h0);
    check("t3_rdata5", 64'(rdata_z[DW-1:0]), 64'h12);

    // Same-edge set and write to one index: set wins, data still written.
    drive(1'b0, 0, '0, 1'b1, 9, 9, 9);
    step("t4_set9");
    drive(1'b1, 9, 32'h55, 1'b1, 9, 9, 9);
    step("t4_coll");
    check("t4_cnt", 64'(cnt_z), 64'h2);
    check("t4_rbusy", 64'(rbusy_z[0]), 64'h1);
    check("t4_rdata", 64'(rdata_z[DW-1:0]), 64'h55);

    // Both ports reading an entry being written this cycle.
    drive(1'b1, 4, 32'hA5A5_A5A5, 1'b0, 0, 4, 4);
    #1;
`ifdef PRF_BYPASS_EN
    check("t5_pre_p0", 64'(rdata_z[DW-1:0]), 64'hA5A5_A5A5);
    check("t5_pre_p1", 64'(rdata_z[2*DW-1:DW]), 64'hA5A5_A5A5);
`else
    check("t5_pre_p0", 64'(rdata_z[DW-1:0]), 64'h0);
    check("t5_pre_p1", 64'(rdata_z[2*DW-1:DW]), 64'h0);
`endif
    step("t5_byp");
    check("t5_post_p0", 64'(rdata_z[DW-1:0]), 64'hA5A5_A5A5);
    check("t5_post_p1", 64'(rdata_z[2*DW-1:DW]), 64'hA5A5_A5A5);

    // Fill the scoreboard and confirm the count saturates at the number of busy entries.
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
    do_reset("t6_rst");
    for (int i = 1; i < NREG; i++) begin
      drive(1'b0, 0, '0, 1'b1, i, i, i - 1);
      step("t6_fill");
    end
    check("t6_cnt_z31", 64'(cnt_z), 64'd31);
    check("t6_cnt_n31", 64'(cnt_n), 64'd31);
    drive(1'b0, 0, '0, 1'b1, 31, 31, 0);
    step("t6_reset31");
    check("t6_nowrap_z", 64'(cnt_z), 64'd31);
    drive(1'b0, 0, '0, 1'b1, 0, 31, 0);
    step("t6_set0");
    check("t6_max_z", 64'(cnt_z), 64'd31);
    check("t6_max_n", 64'(cnt_n), 64'd32);

    // Random traffic, biased toward low indices to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), pick_addr(), DW'($urandom),
            1'($urandom_range(0, 1)), pick_addr(), pick_addr(), pick_addr());
      if (n % 97 == 96) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
